i2c_bus_arbiter: RTL and testbench

- Shares one I2C master command interface between two requester FSMs, e.g. a sensor-polling sequencer and a configuration sequencer.
- The interface covers start, address, nbytes, write data and read data, all valid/ready.
- Arbitration is round-robin and locked per transaction: a grant is held from request until the master signals done or nack, or a timeout fires.
- Sits between the requester FSMs and the I2C master core.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/i2c_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus arbiter slice: FSM states, requester
// indices and the default data bus width.
package i2c_pkg;

  localparam int unsigned I2C_DATA_DEPTH = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the requester that did not win last time gets
// priority; a lone requester always wins. Purely combinational.
module rr_arbiter2
  import i2c_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // Priority goes to the requester that is not 'last'
  always_comb begin
    win = '0;
    if (last == REQ1) begin
      if (req[0])      win = 2'b01;
      else if (req[1]) win = 2'b10;
    end else begin
      if (req[1])      win = 2'b10;
      else if (req[0]) win = 2'b01;
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master command interface between two requester FSMs.
// The grant is locked per transaction and released on master done/nack,
// a timeout, or a requester dropping its request before issuing start.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_DEPTH     = I2C_DATA_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_req,
  output logic [1:0]              o_gnt,
  input  logic [1:0]              i_start,
  input  logic [2*DATA_DEPTH-1:0] i_addr_bits,
  input  logic [1:0]              i_addr_valid,
  output logic [1:0]              o_addr_ready,
  input  logic [2*DATA_DEPTH-1:0] i_nbytes_bits,
  input  logic [1:0]              i_nbytes_valid,
  output logic [1:0]              o_nbytes_ready,
  input  logic [2*DATA_DEPTH-1:0] i_wr_bits,
  input  logic [1:0]              i_wr_valid,
  output logic [1:0]              o_wr_ready,
  output logic [DATA_DEPTH-1:0]   o_rd_bits,
  output logic [1:0]              o_rd_valid,
  input  logic [1:0]              i_rd_ready,
  output logic [1:0]              o_done,
  output logic [1:0]              o_nack,
  output logic                    o_timeout,
  output logic                    o_m_start,
  output logic [DATA_DEPTH-1:0]   o_m_addr_bits,
  output logic                    o_m_addr_valid,
  input  logic                    i_m_addr_ready,
  output logic [DATA_DEPTH-1:0]   o_m_nbytes_bits,
  output logic                    o_m_nbytes_valid,
  input  logic                    i_m_nbytes_ready,
  output logic [DATA_DEPTH-1:0]   o_m_wr_bits,
  output logic                    o_m_wr_valid,
  input  logic                    i_m_wr_ready,
  input  logic [DATA_DEPTH-1:0]   i_m_rd_bits,
  input  logic                    i_m_rd_valid,
  output logic                    o_m_rd_ready,
  input  logic                    i_m_done,
  input  logic                    i_m_nack
);

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [1:0]       gnt_n;
  logic             owner, owner_n;
  logic             last, last_n;
  logic             started;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       done_n, nack_n;
  logic             timeout_n;
  logic [1:0]       win;
  logic             busy;
  logic             to_hit;
  logic             exit_busy;

  rr_arbiter2 u_rr (
    .req  (i_req),
    .last (last),
    .win  (win)
  );

  assign busy   = (state == BUSY);
  assign to_hit = TO_EN && (cnt == TO_LAST);

  // Owner-selected channel mux; everything toward either side is gated off outside BUSY
  always_comb begin
    o_m_addr_bits   = owner ? i_addr_bits[2*DATA_DEPTH-1:DATA_DEPTH]   : i_addr_bits[DATA_DEPTH-1:0];
    o_m_nbytes_bits = owner ? i_nbytes_bits[2*DATA_DEPTH-1:DATA_DEPTH] : i_nbytes_bits[DATA_DEPTH-1:0];
    o_m_wr_bits     = owner ? i_wr_bits[2*DATA_DEPTH-1:DATA_DEPTH]     : i_wr_bits[DATA_DEPTH-1:0];
    o_rd_bits        = i_m_rd_bits;
    o_m_start        = busy & i_start[owner];
    o_m_addr_valid   = busy & i_addr_valid[owner];
    o_m_nbytes_valid = busy & i_nbytes_valid[owner];
    o_m_wr_valid     = busy & i_wr_valid[owner];
    o_m_rd_ready     = busy & i_rd_ready[owner];
    o_addr_ready     = '0;
    o_nbytes_ready   = '0;
    o_wr_ready       = '0;
    o_rd_valid       = '0;
    if (busy) begin
      o_addr_ready[owner]   = i_m_addr_ready;
      o_nbytes_ready[owner] = i_m_nbytes_ready;
      o_wr_ready[owner]     = i_m_wr_ready;
      o_rd_valid[owner]     = i_m_rd_valid;
    end
  end

  // Next-state logic; nack outranks done, done outranks timeout, and a
  // start pulse in the current cycle already counts as having started
  always_comb begin
    state_n   = state;
    gnt_n     = o_gnt;
    owner_n   = owner;
    last_n    = last;
    done_n    = '0;
    nack_n    = '0;
    timeout_n = 1'b0;
    exit_busy = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_n = BUSY;
          gnt_n   = win;
          owner_n = win[1];
        end
      end
      BUSY: begin
        if (i_m_nack) begin
          nack_n[owner] = 1'b1;
          exit_busy     = 1'b1;
        end else if (i_m_done) begin
          done_n[owner] = 1'b1;
          exit_busy     = 1'b1;
        end else if (to_hit) begin
          timeout_n     = 1'b1;
          nack_n[owner] = 1'b1;
          exit_busy     = 1'b1;
        end else if (!i_req[owner] && !started && !o_m_start) begin
          exit_busy     = 1'b1;
        end
        if (exit_busy) begin
          state_n = GAP;
          gnt_n   = '0;
          last_n  = owner;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, grant and pulse registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      o_gnt     <= '0;
      owner     <= REQ0;
      last      <= REQ1;
      o_done    <= '0;
      o_nack    <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      o_gnt     <= gnt_n;
      owner     <= owner_n;
      last      <= last_n;
      o_done    <= done_n;
      o_nack    <= nack_n;
      o_timeout <= timeout_n;
    end
  end

  // Started flag and timeout counter, both live only while BUSY
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      started <= 1'b0;
      cnt     <= '0;
    end else if (!busy) begin
      started <= 1'b0;
      cnt     <= '0;
    end else begin
      if (o_m_start) started <= 1'b1;
      if (TO_EN)     cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter (timeout set to 16 cycles).
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = '0, start = '0;
  logic [2*DW-1:0] addr_bits = '0, nbytes_bits = '0, wr_bits = '0;
  logic [1:0]    addr_valid = '0, nbytes_valid = '0, wr_valid = '0, rd_ready = '0;
  logic [1:0]    gnt, addr_ready, nbytes_ready, wr_ready, rd_valid, done, nack;
  logic [DW-1:0] rd_bits;
  logic          timeout;
  logic          m_start, m_addr_valid, m_nbytes_valid, m_wr_valid, m_rd_ready;
  logic [DW-1:0] m_addr_bits, m_nbytes_bits, m_wr_bits;
  logic          m_addr_ready = 1'b0, m_nbytes_ready = 1'b0, m_wr_ready = 1'b0;
  logic [DW-1:0] m_rd_bits = '0;
  logic          m_rd_valid = 1'b0, m_done = 1'b0, m_nack = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.DATA_DEPTH(DW), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt), .i_start(start),
    .i_addr_bits(addr_bits), .i_addr_valid(addr_valid), .o_addr_ready(addr_ready),
    .i_nbytes_bits(nbytes_bits), .i_nbytes_valid(nbytes_valid), .o_nbytes_ready(nbytes_ready),
    .i_wr_bits(wr_bits), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_rd_bits(rd_bits), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .o_done(done), .o_nack(nack), .o_timeout(timeout),
    .o_m_start(m_start),
    .o_m_addr_bits(m_addr_bits), .o_m_addr_valid(m_addr_valid), .i_m_addr_ready(m_addr_ready),
    .o_m_nbytes_bits(m_nbytes_bits), .o_m_nbytes_valid(m_nbytes_valid), .i_m_nbytes_ready(m_nbytes_ready),
    .o_m_wr_bits(m_wr_bits), .o_m_wr_valid(m_wr_valid), .i_m_wr_ready(m_wr_ready),
    .i_m_rd_bits(m_rd_bits), .i_m_rd_valid(m_rd_valid), .o_m_rd_ready(m_rd_ready),
    .i_m_done(m_done), .i_m_nack(m_nack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_nack", nack, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    rst = 1'b0;

    // Single requester 0 transaction
    req = 2'b01;
    #1 chk("t1_gnt_before_edge", gnt, 2'b00);
    tick();
    chk("t1_gnt", gnt, 2'b01);
    start = 2'b01; addr_bits = {8'h11, 8'h4E}; addr_valid = 2'b01;
    nbytes_bits = {8'h07, 8'h02}; nbytes_valid = 2'b01;
    m_addr_ready = 1'b1; m_nbytes_ready = 1'b1;
    #1;
    chk("t1_m_start", m_start, 1'b1);
    chk("t1_m_addr_bits", m_addr_bits, 8'h4E);
    chk("t1_m_addr_valid", m_addr_valid, 1'b1);
    chk("t1_addr_ready", addr_ready, 2'b01);
    chk("t1_m_nbytes_bits", m_nbytes_bits, 8'h02);
    chk("t1_nbytes_ready", nbytes_ready, 2'b01);
    tick();
    start = 2'b00; addr_valid = 2'b00; nbytes_valid = 2'b00;
    m_rd_bits = 8'hA5; m_rd_valid = 1'b1; rd_ready = 2'b01;
    #1;
    chk("t1_rd_valid0", rd_valid, 2'b01);
    chk("t1_rd_bits0", rd_bits, 8'hA5);
    chk("t1_m_rd_ready", m_rd_ready, 1'b1);
    tick();
    m_rd_bits = 8'h3C;
    #1;
    chk("t1_rd_valid1", rd_valid, 2'b01);
    chk("t1_rd_bits1", rd_bits, 8'h3C);
    tick();
    m_rd_valid = 1'b0; rd_ready = 2'b00; m_done = 1'b1;
    #1 chk("t1_done_before_edge", done, 2'b00);
    tick();
    m_done = 1'b0; req = 2'b00; addr_valid = 2'b01;
    chk("t1_done_pulse", done, 2'b01);
    chk("t1_gap_gnt", gnt, 2'b00);
    #1;
    chk("t1_gap_m_addr_valid", m_addr_valid, 1'b0);
    chk("t1_gap_addr_ready", addr_ready, 2'b00);
    tick();
    addr_valid = 2'b00;
    chk("t1_done_cleared", done, 2'b00);
    chk("t1_idle_gnt", gnt, 2'b00);

    // Simultaneous requests from fresh reset: 0 first, then 1, then 0
    rst = 1'b1; #1 rst = 1'b0;
    req = 2'b11;
    tick();
    chk("t2_gnt_first", gnt, 2'b01);
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("t2_done0", done, 2'b01);
    chk("t2_gap_gnt", gnt, 2'b00);
    tick();
    chk("t2_idle_gnt", gnt, 2'b00);
    tick();
    chk("t2_gnt_second", gnt, 2'b10);
    wr_bits = {8'h5A, 8'hC3}; wr_valid = 2'b11; m_wr_ready = 1'b1;
    #1;
    chk("t2_m_wr_bits", m_wr_bits, 8'h5A);
    chk("t2_m_wr_valid", m_wr_valid, 1'b1);
    chk("t2_wr_ready", wr_ready, 2'b10);
    wr_valid = 2'b00;

    // NACK during requester 1's transaction
    m_nack = 1'b1;
    tick();
    m_nack = 1'b0;
    chk("t3_nack1", nack, 2'b10);
    chk("t3_done_none", done, 2'b00);
    chk("t3_gnt_clear", gnt, 2'b00);
    tick();
    tick();
    chk("t3_gnt_alternate", gnt, 2'b01);
    m_done = 1'b1; m_nack = 1'b1;
    tick();
    m_done = 1'b0; m_nack = 1'b0; req = 2'b00;
    chk("t3_both_nack", nack, 2'b01);
    chk("t3_both_done", done, 2'b00);
    tick();
    tick();

    // Early release before start: silent
    req = 2'b01;
    tick();
    chk("t4_gnt", gnt, 2'b01);
    req = 2'b00;
    tick();
    chk("t4_silent_gnt", gnt, 2'b00);
    chk("t4_silent_done", done, 2'b00);
    chk("t4_silent_nack", nack, 2'b00);
    tick();
    // Drop after start: grant held until done
    req = 2'b01;
    tick();
    chk("t4b_gnt", gnt, 2'b01);
    start = 2'b01;
    tick();
    start = 2'b00; req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4b_gnt_held", gnt, 2'b01);
    end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("t4b_done", done, 2'b01);
    chk("t4b_gnt_clear", gnt, 2'b00);
    tick();

    // Timeout with a silent master
    req = 2'b10;
    tick();
    chk("t5_gnt", gnt, 2'b10);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_no_timeout_yet", timeout, 1'b0);
    end
    tick();
    req = 2'b00;
    chk("t5_timeout", timeout, 1'b1);
    chk("t5_nack", nack, 2'b10);
    chk("t5_gnt_clear", gnt, 2'b00);
    tick();
    chk("t5_timeout_cleared", timeout, 1'b0);
    chk("t5_nack_cleared", nack, 2'b00);

    // Make requester 0 the last winner, then grant 1 and reset mid-BUSY
    req = 2'b01;
    tick();
    chk("t6_gnt0", gnt, 2'b01);
    req = 2'b00;
    tick();
    tick();
    req = 2'b11;
    tick();
    chk("t6_gnt1", gnt, 2'b10);
    addr_valid = 2'b10;
    #1 chk("t6_m_addr_valid", m_addr_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_gnt", gnt, 2'b00);
    chk("t6_rst_m_addr_valid", m_addr_valid, 1'b0);
    chk("t6_rst_addr_ready", addr_ready, 2'b00);
    rst = 1'b0;
    addr_valid = 2'b00;
    tick();
    chk("t6_tie_after_reset", gnt, 2'b01);
    chk("t6_no_nack", nack, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
